uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart_transmitter` between N byte producers. It selects one pending requester, loads that requester's byte into the transmitter, issues the start request, and acknowledges the requester. It then holds off further grants until the transmitter has finished the frame. It sits between the producer blocks and the transmitter's `start`, `data` and `busy` pins.

## Interface
- `N`, default 4: number of requesters, ≥2; need not be a power of two.
- `W`, default 8: data width per requester.
- `IW`, default `$clog2(N)`: width of `grant_id`.

Ports:
- `clock`  in  1  — single clock; all logic on its rising edge.
- `reset`  in  1  — asynchronous, active-low; 0 resets immediately, release is synchronous to `clock`.
- `req`  in  N  — request from requester i; held high until `ack[i]`.
- `data_in`  in  N*W  — requester i's byte at bits [i*W +: W]; stable while `req[i]` is high.
- `ack`  out  N  — one-hot, one-cycle pulse: the request is accepted by the transmitter.
- `tx_start`  out  1  — to transmitter `start`.
- `tx_data`  out  W  — to transmitter data input; registered.
- `tx_busy`  in  1  — from transmitter `busy`.
- `grant_id`  out  IW  — index of the current or last granted requester; registered.
- `active`  out  1  — high whenever the state is not S_IDLE.

## Operation
- State register has reset value S_IDLE. All outputs reset to 0: `ack`, `tx_start`, `tx_data`, `grant_id` and `active`.
- Round-robin pointer `ptr` (IW bits) resets to 0.
- **S_IDLE**
  - If `tx_busy`=0 and `req`≠0: choose winner w, the first set `req` bit searching from `ptr` upward with wrap modulo N.
  - Register `tx_data`←`data_in[w]`, `grant_id`←w, `ptr`←(w+1) mod N, then go to S_START.
  - If `tx_busy`=1: stay in S_IDLE. No grant is made while the transmitter is busy.
- **S_START**
  - `tx_start`=1.
  - When `tx_busy`=1 is sampled: go to S_WAIT_DONE and register `ack[grant_id]`=1 for exactly the next cycle.
  - While `tx_busy`=0: remain here with `tx_start` held high.
- **S_WAIT_DONE**
  - `tx_start`=0.
  - When `tx_busy`=0 is sampled: go to S_IDLE.
- `tx_start` and `active` are decoded from the state register only (Moore). `ack` is a register.
- `tx_data` and `grant_id` hold their values until the next grant.
- Requester protocol:
  - A requester drops `req` in the cycle after `ack`, or keeps it high to request another byte.
  - A request that stays high after `ack` competes as a new request. Round-robin order guarantees the other requesters are served first.
- Dropping `req[w]` before `ack` is a protocol violation. The arbiter ignores it: the byte is already latched, and the frame and `ack` complete normally.
- Requests arriving in any state other than S_IDLE wait. There is no queueing beyond the `req` level.
- When `reset` is asserted mid-frame, the arbiter returns to S_IDLE at once and clears all outputs and `ptr`. The transmitter is reset by the same reset net.

## Timing
- Grant latency: `req` sampled high at edge k with `tx_busy`=0 gives S_START and `tx_start`=1 from edge k.
- The transmitter samples `start` at k+1 and raises `busy` after k+1. The arbiter samples `busy` at k+2, so `ack` is high in the cycle after edge k+2.
- The transmitter latches `tx_data` while it is idle. `tx_data` is valid from edge k, one cycle before the start edge.
- Back-to-back: `busy` falling, sampled at edge m, gives S_IDLE. The next grant is at m+1 and the next `tx_start` is high from m+1.
- Simultaneous requests at a grant edge: only the winner chosen from `ptr` is served. The other requests are untouched.
- `ptr` wraps from N-1 to 0.

## Test plan
- Reset: `reset`=0 at random points, including mid-S_START and mid-frame → all outputs 0, state S_IDLE and `ptr`=0 immediately; after release, the first grant goes to the lowest pending index.
- Single requester: `req[2]`=1 with `data_in[2]`=8'hA5 and `tx_busy`=0 → `tx_data`=A5 and `grant_id`=2 at edge k; `tx_start` high cycles k..k+1; `ack[2]` pulses once after edge k+2; exactly one frame with A5 is sent.
- Fairness: all four `req` held high continuously with distinct bytes 11, 22, 33, 44 → grant order 0, 1, 2, 3, 0, ... and frames 11, 22, 33, 44, 11.
- Wrap and skip: `ptr`=3 with `req`=4'b0101 → requester 0 granted, then 2; with N=3, `ptr` wraps 2→0.
- Busy hold-off: `tx_busy` forced high in S_IDLE with `req[1]`=1 → no `tx_start` and no `ack` until `busy` drops, then grant on the next edge.
- Early `req` drop: `req[0]` dropped in S_START → the frame still completes, `ack[0]` pulses once and the arbiter returns to S_IDLE.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N byte producers.
// Grants one pending requester per frame and acknowledges it once the transmitter goes busy.
module uart_tx_arbiter #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    output logic [N-1:0]   ack,
    output logic           tx_start,
    output logic [W-1:0]   tx_data,
    input  logic           tx_busy,
    output logic [IW-1:0]  grant_id,
    output logic           active
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE
    } state_t;

    localparam logic [IW:0] N_W = N[IW:0];

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] ptr_next;
    logic [IW:0]   idx;
    logic          found;
    logic          grant;
    logic [W-1:0]  bytes [N];

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            bytes[i] = data_in[i*W +: W];
        end
    end

    // ptr < N, so ptr + i < 2N and one conditional subtraction gives the wrap.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + i[IW:0];
            if (idx >= N_W) begin
                idx = idx - N_W;
            end
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        if ({1'b0, win} == N_W - 1'b1) begin
            ptr_next = '0;
        end else begin
            ptr_next = win + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        tx_start   = 1'b0;
        active     = 1'b1;
        case (state)
            S_IDLE: begin
                active = 1'b0;
                if (!tx_busy && found) begin
                    grant      = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                tx_start = 1'b1;
                if (tx_busy) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            tx_data  <= '0;
            grant_id <= '0;
            ack      <= '0;
        end else begin
            state <= state_next;
            ack   <= '0;
            if (grant) begin
                tx_data  <= bytes[win];
                grant_id <= win;
                ptr      <= ptr_next;
            end
            if (state == S_START && tx_busy) begin
                ack[grant_id] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural transmitter plus a frame scoreboard,
// with a second N=3 instance for pointer wrap on a non-power-of-two size.
module tb_uart_tx_arbiter;

    localparam int FRAME = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;

    logic        model_busy;
    logic        force_busy;
    int          model_cnt;

    logic [2:0]  req3;
    logic [23:0] data3;
    logic [2:0]  ack3;
    logic        tx_start3;
    logic [7:0]  tx_data3;
    logic        busy3;
    logic [1:0]  grant_id3;
    logic        active3;
    int          cnt3;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_count = 0;
    int          push_count = 0;
    int          last_id = 0;
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];

    always #5 clock = ~clock;

    assign tx_busy = model_busy | force_busy;

    uart_tx_arbiter #(.N(4), .W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .data_in  (data_in),
        .ack      (ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .grant_id (grant_id),
        .active   (active)
    );

    uart_tx_arbiter #(.N(3), .W(8)) dut3 (
        .clock    (clock),
        .reset    (reset),
        .req      (req3),
        .data_in  (data3),
        .ack      (ack3),
        .tx_start (tx_start3),
        .tx_data  (tx_data3),
        .tx_busy  (busy3),
        .grant_id (grant_id3),
        .active   (active3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter model: latches tx_data when start is seen while idle.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (!model_busy && tx_start) begin
            model_busy <= 1'b1;
            model_cnt  <= FRAME;
            obs_q.push_back({6'd0, grant_id, tx_data});
        end else if (model_busy) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) model_busy <= 1'b0;
        end
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy3 <= 1'b0;
            cnt3  <= 0;
        end else if (!busy3 && tx_start3) begin
            busy3 <= 1'b1;
            cnt3  <= 3;
        end else if (busy3) begin
            cnt3 <= cnt3 - 1;
            if (cnt3 == 1) busy3 <= 1'b0;
        end
    end

    always @(negedge clock) begin
        logic [15:0] o;
        logic [15:0] e;
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                check_eq("unexpected_frame", {16'd0, o}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("frame_id", {24'd0, o[15:8]}, {24'd0, e[15:8]});
                check_eq("frame_data", {24'd0, o[7:0]}, {24'd0, e[7:0]});
                last_id = int'(e[15:8]);
            end
        end
        if (ack != 4'd0) begin
            ack_count++;
            check_eq("ack_onehot", {28'd0, ack}, 32'd1 << last_id);
        end
    end

    task automatic push_exp(input int id, input logic [7:0] b);
        logic [7:0] id8;
        id8 = 8'(id);
        exp_q.push_back({id8, b});
        push_count++;
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        data_in[i*8 +: 8] = b;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_ack"}, {28'd0, ack}, 32'd0);
        check_eq({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
        check_eq({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check_eq({tag, "_grant_id"}, {30'd0, grant_id}, 32'd0);
        check_eq({tag, "_active"}, {31'd0, active}, 32'd0);
    endtask

    task automatic wait_acks(input int target);
        for (int c = 0; c < 400; c++) begin
            @(posedge clock);
            #2;
            if (ack_count >= target) return;
        end
        check_eq("ack_timeout", ack_count, target);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 400; c++) begin
            @(posedge clock);
            #1;
            if (!active && !tx_busy) return;
        end
        check_eq("idle_timeout", {31'd0, active}, 32'd0);
    endtask

    task automatic wait_start();
        for (int c = 0; c < 400; c++) begin
            @(posedge clock);
            #1;
            if (tx_start) return;
        end
        check_eq("start_timeout", {31'd0, tx_start}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n3;
        logic [1:0] q3 [$];
        logic [7:0] b3 [3];
        logic [1:0] e3;

        reset = 1'b0; req = '0; data_in = '0; force_busy = 1'b0;
        req3 = '0; data3 = '0;
        repeat (3) @(posedge clock);
        #1 check_zero("reset");
        @(negedge clock) reset = 1'b1;

        // single requester, cycle-exact timing
        @(negedge clock);
        base = ack_count;
        set_byte(2, 8'hA5); req = 4'b0100; push_exp(2, 8'hA5);
        @(posedge clock); #1;
        check_eq("single_start_k", {31'd0, tx_start}, 32'd1);
        check_eq("single_tx_data", {24'd0, tx_data}, 32'hA5);
        check_eq("single_grant_id", {30'd0, grant_id}, 32'd2);
        check_eq("single_active", {31'd0, active}, 32'd1);
        @(posedge clock); #1;
        check_eq("single_start_k1", {31'd0, tx_start}, 32'd1);
        check_eq("single_ack_k1", {28'd0, ack}, 32'd0);
        @(posedge clock); #1;
        check_eq("single_start_k2", {31'd0, tx_start}, 32'd0);
        check_eq("single_ack_k2", {28'd0, ack}, 32'h4);
        @(posedge clock); #1;
        check_eq("single_ack_k3", {28'd0, ack}, 32'd0);
        req = '0;
        wait_idle();
        check_eq("single_ack_count", ack_count, base + 1);

        // busy hold-off
        force_busy = 1'b1;
        set_byte(1, 8'h5A); req = 4'b0010; push_exp(1, 8'h5A);
        base = ack_count;
        repeat (5) begin
            @(posedge clock); #1;
            check_eq("hold_no_start", {31'd0, tx_start}, 32'd0);
            check_eq("hold_no_ack", {28'd0, ack}, 32'd0);
        end
        @(negedge clock) force_busy = 1'b0;
        @(posedge clock); #1;
        check_eq("hold_start", {31'd0, tx_start}, 32'd1);
        check_eq("hold_grant_id", {30'd0, grant_id}, 32'd1);
        wait_acks(base + 1);
        req = '0;
        wait_idle();

        // reset while in S_START
        set_byte(3, 8'h77); req = 4'b1000;
        wait_start();
        check_eq("rst_start_gid", {30'd0, grant_id}, 32'd3);
        reset = 1'b0;
        #1 check_zero("rst_start");
        req = '0;
        @(negedge clock) reset = 1'b1;

        // fairness with all requests held
        set_byte(0, 8'h11); set_byte(1, 8'h22); set_byte(2, 8'h33); set_byte(3, 8'h44);
        push_exp(0, 8'h11); push_exp(1, 8'h22); push_exp(2, 8'h33);
        push_exp(3, 8'h44); push_exp(0, 8'h11);
        base = ack_count;
        req = 4'hF;
        wait_acks(base + 5);
        req = '0;
        wait_idle();

        // wrap and skip: steer ptr to 3, then req = 0101
        base = ack_count;
        set_byte(2, 8'h5C); req = 4'b0100; push_exp(2, 8'h5C);
        wait_acks(base + 1);
        req = '0;
        set_byte(0, 8'hE0); set_byte(2, 8'hE2);
        push_exp(0, 8'hE0); push_exp(2, 8'hE2);
        req = 4'b0101;
        wait_acks(base + 2);
        req[0] = 1'b0;
        wait_acks(base + 3);
        req = '0;
        wait_idle();

        // early drop of req during S_START
        base = ack_count;
        set_byte(0, 8'h99); req = 4'b0001; push_exp(0, 8'h99);
        wait_start();
        req = '0;
        wait_acks(base + 1);
        wait_idle();
        check_eq("early_drop_acks", ack_count, base + 1);
        check_eq("early_drop_idle", {31'd0, active}, 32'd0);

        // reset mid-frame, then lowest pending index wins
        base = ack_count;
        set_byte(1, 8'h3C); req = 4'b0010; push_exp(1, 8'h3C);
        wait_acks(base + 1);
        req = '0;
        check_eq("midframe_busy", {31'd0, tx_busy}, 32'd1);
        reset = 1'b0;
        #1 check_zero("rst_frame");
        set_byte(3, 8'hD4); req = 4'b1010;
        push_exp(1, 8'h3C); push_exp(3, 8'hD4);
        @(negedge clock) reset = 1'b1;
        wait_acks(base + 2);
        req[1] = 1'b0;
        wait_acks(base + 3);
        req = '0;
        wait_idle();

        // N=3 instance: ptr wraps 2 -> 0
        b3[0] = 8'hA0; b3[1] = 8'hB1; b3[2] = 8'hC2;
        data3 = {b3[2], b3[1], b3[0]};
        q3.push_back(2'd0); q3.push_back(2'd1); q3.push_back(2'd2); q3.push_back(2'd0);
        n3 = 0;
        req3 = 3'b111;
        for (int c = 0; c < 300 && n3 < 4; c++) begin
            @(posedge clock); #1;
            if (ack3 != 3'd0) begin
                e3 = q3.pop_front();
                check_eq("n3_grant_id", {30'd0, grant_id3}, {30'd0, e3});
                check_eq("n3_ack", {29'd0, ack3}, 32'd1 << e3);
                check_eq("n3_tx_data", {24'd0, tx_data3}, {24'd0, b3[e3]});
                n3++;
            end
        end
        req3 = '0;
        check_eq("n3_grants", n3, 4);

        repeat (20) @(posedge clock);
        #1;
        check_eq("frames_outstanding", exp_q.size(), 0);
        check_eq("total_acks", ack_count, push_count);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
